// File: rtl/iob_ram_sp_be_clr_pkg.sv
// Shared encodings and helpers for the byte-enable RAM with clear engine.
package iob_ram_sp_be_clr_pkg;

    localparam int RD_FIRST  = 0;
    localparam int WR_FIRST  = 1;
    localparam int NO_CHANGE = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int num_col(input int data_w, input int col_w);
        return data_w / col_w;
    endfunction

endpackage

// File: rtl/iob_ram_sp_be_clr_if.sv
// Request/response bus of the byte-enable RAM; the RAM sits on the slave side.
interface iob_ram_sp_be_clr_if
    import iob_ram_sp_be_clr_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int COL_W  = 8
);
    localparam int NUM_COL = num_col(DATA_W, COL_W);

    logic               req_valid_i;
    logic               req_ready_o;
    logic [NUM_COL-1:0] we_i;
    logic [ADDR_W-1:0]  addr_i;
    logic [DATA_W-1:0]  d_i;
    logic               rsp_valid_o;
    logic [DATA_W-1:0]  d_o;

    modport slave (
        input  req_valid_i, we_i, addr_i, d_i,
        output req_ready_o, rsp_valid_o, d_o
    );

    modport master (
        output req_valid_i, we_i, addr_i, d_i,
        input  req_ready_o, rsp_valid_o, d_o
    );

endinterface

// File: rtl/iob_ram_sp_be_clr_ctrl.sv
// Sequencer: clear/run FSM, clear address counter, ready/busy and the array port mux.
//   state    | meaning
//   ST_CLEAR | one word per cycle gets CLR_VAL, ascending address; requests blocked
//   ST_RUN   | requests accepted, one per cycle
module iob_ram_sp_be_clr_ctrl
    import iob_ram_sp_be_clr_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter int                NUM_COL    = 4,
    parameter int                CLR_ON_RST = 1,
    parameter logic [DATA_W-1:0] CLR_VAL    = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_clr,
    input  logic               i_req_valid,
    input  logic [NUM_COL-1:0] i_we,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [DATA_W-1:0]  i_d,
    output logic               o_req_ready,
    output logic               o_busy,
    output logic               o_acc,
    output logic [NUM_COL-1:0] o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [DATA_W-1:0]  o_mem_wdata
);
    localparam logic [ADDR_W-1:0] CNT_LAST  = '1;
    localparam state_t            RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ready;
    logic              w_acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == ST_CLEAR) ? r_cnt + 1'b1 : '0;
            // ready follows the next state so it drops together with busy rising
            r_ready <= (w_state_nxt == ST_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_cnt == CNT_LAST) w_state_nxt = ST_RUN;
            ST_RUN:   if (i_clr)             w_state_nxt = ST_CLEAR;
            default:  w_state_nxt = RST_STATE;
        endcase
    end

    assign w_acc = i_req_valid & r_ready;

    always_comb begin
        o_mem_we    = '0;
        o_mem_addr  = i_addr;
        o_mem_wdata = i_d;
        if (r_state == ST_CLEAR) begin
            o_mem_we    = '1;
            o_mem_addr  = r_cnt;
            o_mem_wdata = CLR_VAL;
        end else if (w_acc) begin
            o_mem_we = i_we;
        end
    end

    assign o_req_ready = r_ready;
    assign o_busy      = (r_state == ST_CLEAR);
    assign o_acc       = w_acc;

endmodule

// File: rtl/iob_ram_sp_be_clr.sv
// Single-port byte-enable RAM with valid/ready requests, selectable read-during-write
// behaviour, optional output register and a built-in clear engine.
module iob_ram_sp_be_clr
    import iob_ram_sp_be_clr_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter int                COL_W      = 8,
    parameter int                READ_MODE  = RD_FIRST,
    parameter int                OUT_REG    = 0,
    parameter int                CLR_ON_RST = 1,
    parameter logic [DATA_W-1:0] CLR_VAL    = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    output logic                 busy_o,
    iob_ram_sp_be_clr_if.slave   bus
);
    localparam int NUM_COL = num_col(DATA_W, COL_W);
    localparam int DEPTH   = 2 ** ADDR_W;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_acc;
    logic               w_wr;
    logic [NUM_COL-1:0] w_mem_we;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0]  w_mem_wdata;
    logic [DATA_W-1:0]  w_rd_word;
    logic [DATA_W-1:0]  w_merged;

    logic               r_v1;
    logic [DATA_W-1:0]  r_d1;

    iob_ram_sp_be_clr_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_COL    (NUM_COL),
        .CLR_ON_RST (CLR_ON_RST),
        .CLR_VAL    (CLR_VAL)
    ) u_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_clr       (clr_i),
        .i_req_valid (bus.req_valid_i),
        .i_we        (bus.we_i),
        .i_addr      (bus.addr_i),
        .i_d         (bus.d_i),
        .o_req_ready (bus.req_ready_o),
        .o_busy      (busy_o),
        .o_acc       (w_acc),
        .o_mem_we    (w_mem_we),
        .o_mem_addr  (w_mem_addr),
        .o_mem_wdata (w_mem_wdata)
    );

    assign w_wr = |bus.we_i;

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_COL; c++) begin
            if (w_mem_we[c]) r_mem[w_mem_addr][c*COL_W +: COL_W] <= w_mem_wdata[c*COL_W +: COL_W];
        end
    end

    always_comb begin
        w_rd_word = r_mem[w_mem_addr];
        w_merged  = w_rd_word;
        for (int c = 0; c < NUM_COL; c++) begin
            if (bus.we_i[c]) w_merged[c*COL_W +: COL_W] = bus.d_i[c*COL_W +: COL_W];
        end
    end

    // no-change mode leaves the data stage untouched on writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_acc;
            if (w_acc) begin
                if (!w_wr || READ_MODE == RD_FIRST) r_d1 <= w_rd_word;
                else if (READ_MODE == WR_FIRST)     r_d1 <= w_merged;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              r_v2;
            logic [DATA_W-1:0] r_d2;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) r_d2 <= r_d1;
                end
            end

            assign bus.rsp_valid_o = r_v2;
            assign bus.d_o         = r_d2;
        end else begin : g_noreg
            assign bus.rsp_valid_o = r_v1;
            assign bus.d_o         = r_d1;
        end
    endgenerate

endmodule
